noc_mem_arbiter: RTL and testbench
==================================

Name: noc_mem_arbiter

Overview:
N-channel request arbiter and response router between several NoC requesters (cores) and a single memory_interface port.
- Round-robin arbitration over per-channel valid/ready request ports.
- Registered forwarding of the winning request to the memory side.
- Tracks outstanding read-type requests in a route FIFO so that in-order memory responses return to the correct channel.
- Generalises the single core-to-memory point-to-point link to N_CH requesters.

Parameters:
N_CH, 2, number of requester channels (2..8)
DAT_BYTES, 32, payload bytes per flit
ROUTE_DEPTH, 4, maximum outstanding response-expecting requests (power of two)
CH_W, $clog2(N_CH), channel-ID width (derived; not overridden)

Ports:
fclk  in  1  fabric clock; all logic on rising edge
rst  in  1  asynchronous, active-high reset
req_dat  in  N_CH x DAT_BYTES x 8  per-channel request payload
req_bp  in  N_CH x 6  per-channel byte pointer/length field
req_rsp  in  N_CH  1 = request expects a response (read)
req_vld  in  N_CH  request valid
req_rdy  out  N_CH  request accepted when vld&rdy
mem_dat  out  DAT_BYTES x 8  forwarded payload
mem_bp  out  6  forwarded byte pointer
mem_vld  out  1  forwarded request valid
mem_rdy  in  1  memory side accepts
rin_dat  in  DAT_BYTES x 8  response payload from memory
rin_bp  in  6  response byte pointer
rin_vld  in  1  response valid
rin_rdy  out  1  response accepted
rsp_dat  out  DAT_BYTES x 8  response payload, broadcast to all channels
rsp_bp  out  6  response byte pointer, broadcast
rsp_vld  out  N_CH  one-hot response valid
rsp_rdy  in  N_CH  per-channel response ready
err_orphan  out  1  sticky: response arrived with no outstanding request

Behaviour:
- Reset (async, rst=1):
  - mem_vld=0, mem_dat=0, mem_bp=0.
  - Route FIFO empty; RR pointer selects channel 0 as highest priority.
  - err_orphan=0.
  - Any in-flight output flit is discarded.
- Output register:
  - Single-entry output register, "free" when mem_vld=0 or mem_vld&mem_rdy this cycle.
  - mem_* hold stable while mem_vld&!mem_rdy.
- Eligibility: channel i is eligible when req_vld[i] and (req_rsp[i]=0 or route FIFO can accept).
  - FIFO can accept when count<ROUTE_DEPTH, or a response pop occurs this cycle.
- Grant:
  - When the output register is free, grant the first eligible channel at or after rr_ptr (wrapping modulo N_CH).
  - req_rdy is one-hot on the grant and 0 for all other channels; req_rdy is 0 for all channels when the register is not free.
  - The granted flit appears on mem_* the next cycle (1-cycle latency).
  - Back-to-back grants sustain 1 flit/cycle while mem_rdy=1.
- rr_ptr: on grant of channel g, rr_ptr <= (g+1) mod N_CH; unchanged when no grant.
- Route FIFO:
  - On a granted request with req_rsp=1, push its channel ID.
  - Posted requests (req_rsp=0) bypass the FIFO and are never blocked by FIFO full.
- Response path (combinational):
  - FIFO non-empty: rsp_vld[head]=rin_vld; all other rsp_vld bits 0; rin_rdy=rsp_rdy[head]; rsp_dat=rin_dat, rsp_bp=rin_bp.
  - Pop when rin_vld&rin_rdy.
  - FIFO empty: rsp_vld=0, rin_rdy=1; a response with rin_vld=1 is dropped and sets err_orphan.
- Simultaneous push and pop at full: both occur and count is unchanged.
- Push and pop while empty: the pop does not use the pushed entry; the pushed entry is stored, and the response is handled as orphan.
- Reset mid-operation: all state is cleared, including outstanding routes. Responses arriving later flag err_orphan.

Optional Feature:
NOC_ARB_PERF_CNT_EN
- Defined: adds output grant_cnt (N_CH x 32). A per-channel counter increments on each grant, saturates at 2^32-1, and clears on rst. Adds a stall_cnt (32) that increments each cycle mem_vld&!mem_rdy.
- Undefined: ports and counters are absent; functionality is otherwise identical.

Decomposition:
- Shared package noc_pkg: noc_flit_t struct (dat [DAT_BYTES-1:0][7:0], bp [5:0]), NOC_BP_W=6, noc_ch_id_t.
- One sub-module: noc_route_fifo (parametrised depth/width sync FIFO with count, full, empty, simultaneous push/pop).
- The RR arbiter stays inline.

Test Plan:
- Reset: rst=1 mid-transfer with mem_vld=1 -> mem_vld=0 and rsp_vld=0 immediately (async); err_orphan=0.
- Fairness: N_CH=2, both req_vld held high, mem_rdy=1 -> grants alternate 0,1,0,1; each flit on mem_* one cycle after its handshake.
- Backpressure: mem_rdy=0 for 5 cycles with flit A held -> mem_dat stays A, req_rdy=0 throughout; flit B follows the cycle after mem_rdy=1.
- Route full: ROUTE_DEPTH=4, four reads from ch1 and no responses; fifth read blocked; posted write from ch0 still granted. One response popped -> read granted the same cycle.
- Routing: reads issued ch0, ch1, ch0; responses R1..R3 -> rsp_vld = 01, 10, 01 in order. Holding rsp_rdy[1]=0 stalls rin_rdy=0.
- Orphan: rin_vld=1 with FIFO empty -> rin_rdy=1, rsp_vld=0, err_orphan=1 and stays set until rst.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared definitions for the NoC-to-memory request arbiter.
//   NOC_BP_W      : width of the byte pointer / length field carried with each flit
//   NOC_DAT_BYTES : default payload size of one flit in bytes
//   NOC_MAX_CH    : largest supported number of requester channels
//   noc_ch_id_t   : channel identifier wide enough for NOC_MAX_CH channels
//   noc_flit_t    : one request/response flit (payload plus byte pointer)
//   noc_next_ch() : round-robin successor of a channel id
package noc_pkg;

  localparam int NOC_BP_W      = 6;
  localparam int NOC_DAT_BYTES = 32;
  localparam int NOC_MAX_CH    = 8;

  typedef logic [$clog2(NOC_MAX_CH)-1:0] noc_ch_id_t;

  typedef struct packed {
    logic [NOC_DAT_BYTES-1:0][7:0] dat;
    logic [NOC_BP_W-1:0]           bp;
  } noc_flit_t;

  // Channel that follows ch when n channels are arbitrated in a ring.
  function automatic noc_ch_id_t noc_next_ch(noc_ch_id_t ch, int n);
    return noc_ch_id_t'((int'(ch) + 1) % n);
  endfunction

endpackage

// File: rtl/noc_mem_arbiter_if.sv
// Bundle of every handshake and data signal between the requesters, the
// arbiter and the memory port.
//   slave  : arbiter side (consumes requests and responses from memory)
//   master : environment side (requesters, memory model)
// Signal groups: req_* (per-channel requests), mem_* (forwarded request),
// rin_* (response from memory), rsp_* (response to channels), err_orphan.
//
// Handshake rule for every valid/ready pair here: a transfer happens on a
// rising clock edge where both valid and ready are 1. The producer keeps the
// payload stable while valid=1 and ready=0; ready may depend combinationally
// on valid, but valid never depends on ready.
interface noc_mem_arbiter_if #(
  parameter int N_CH      = 2,
  parameter int DAT_BYTES = 32
);
  import noc_pkg::*;

  logic [N_CH-1:0][DAT_BYTES*8-1:0] req_dat;
  logic [N_CH-1:0][NOC_BP_W-1:0]    req_bp;
  logic [N_CH-1:0]                  req_rsp;
  logic [N_CH-1:0]                  req_vld;
  logic [N_CH-1:0]                  req_rdy;

  logic [DAT_BYTES*8-1:0]           mem_dat;
  logic [NOC_BP_W-1:0]              mem_bp;
  logic                             mem_vld;
  logic                             mem_rdy;

  logic [DAT_BYTES*8-1:0]           rin_dat;
  logic [NOC_BP_W-1:0]              rin_bp;
  logic                             rin_vld;
  logic                             rin_rdy;

  logic [DAT_BYTES*8-1:0]           rsp_dat;
  logic [NOC_BP_W-1:0]              rsp_bp;
  logic [N_CH-1:0]                  rsp_vld;
  logic [N_CH-1:0]                  rsp_rdy;

  logic                             err_orphan;

  modport slave (
    input  req_dat, req_bp, req_rsp, req_vld,
    output req_rdy,
    output mem_dat, mem_bp, mem_vld,
    input  mem_rdy,
    input  rin_dat, rin_bp, rin_vld,
    output rin_rdy,
    output rsp_dat, rsp_bp, rsp_vld,
    input  rsp_rdy,
    output err_orphan
  );

  modport master (
    output req_dat, req_bp, req_rsp, req_vld,
    input  req_rdy,
    input  mem_dat, mem_bp, mem_vld,
    output mem_rdy,
    output rin_dat, rin_bp, rin_vld,
    input  rin_rdy,
    input  rsp_dat, rsp_bp, rsp_vld,
    output rsp_rdy,
    input  err_orphan
  );

endinterface

// File: rtl/noc_route_fifo.sv
// Synchronous FIFO holding the channel id of every outstanding
// response-expecting request, oldest first.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   push_i       : store wdata_i (ignored when full unless a pop happens too)
//   pop_i        : drop the head entry (ignored when empty)
//   wdata_i      : channel id to store
//   rdata_o      : head entry (valid when empty_o=0)
//   full_o       : DEPTH entries stored
//   empty_o      : no entries stored
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
module noc_route_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 1,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
  assign rdata_o = mem_q[rd_ptr_q];

  // A pop frees a slot in the same cycle, so push at full is allowed then.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (do_push && !do_pop)      count_q <= count_q + (PTR_W+1)'(1);
      else if (!do_push && do_pop) count_q <= count_q - (PTR_W+1)'(1);
    end
  end

  // Storage needs no reset: entries are only read once counted.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/noc_mem_arbiter.sv
// N-channel round-robin request arbiter in front of a single memory port,
// with in-order response routing back to the issuing channel.
//   fclk, rst : fabric clock, asynchronous active-high reset
//   bus       : noc_mem_arbiter_if.slave (req_*, mem_*, rin_*, rsp_*, err_orphan)
//   grant_cnt, stall_cnt : per-channel grant counters and memory stall
//             counter, present only when NOC_ARB_PERF_CNT_EN is defined
// Requests win a single-entry output register; the winner appears on mem_*
// one cycle after its handshake. Read-type requests record their channel in
// a route FIFO so memory responses (returned in order) reach the right
// channel. A response with nothing outstanding is dropped and flagged.
module noc_mem_arbiter
  import noc_pkg::*;
#(
  parameter int N_CH        = 2,
  parameter int DAT_BYTES   = NOC_DAT_BYTES,
  parameter int ROUTE_DEPTH = 4,
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                  fclk,
  input  logic                  rst,
  noc_mem_arbiter_if.slave      bus
`ifdef NOC_ARB_PERF_CNT_EN
  ,
  output logic [N_CH-1:0][31:0] grant_cnt,
  output logic [31:0]           stall_cnt
`endif
);

  logic                   vld_q, vld_d;
  logic [DAT_BYTES*8-1:0] dat_q, dat_d;
  logic [NOC_BP_W-1:0]    bp_q, bp_d;
  logic [CH_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic                   err_q, err_d;

  logic                   out_free, fire, push, rsp_pop, fifo_can_accept;
  logic                   fifo_full, fifo_empty;
  logic [CH_W-1:0]        route_head;
  logic [N_CH-1:0]        elig;
  logic                   gnt_found;
  logic [CH_W-1:0]        gnt_idx;

  // ---------------- response path ----------------
  always_comb begin
    bus.rsp_vld = '0;
    bus.rin_rdy = 1'b1;   // empty FIFO: swallow orphan responses
    if (!fifo_empty) begin
      bus.rsp_vld[route_head] = bus.rin_vld;
      bus.rin_rdy             = bus.rsp_rdy[route_head];
    end
  end

  assign bus.rsp_dat = bus.rin_dat;
  assign bus.rsp_bp  = bus.rin_bp;
  assign rsp_pop     = !fifo_empty && bus.rin_vld && bus.rin_rdy;

  // ---------------- arbitration ----------------
  assign out_free        = !vld_q || bus.mem_rdy;
  assign fifo_can_accept = !fifo_full || rsp_pop;
  assign elig            = bus.req_vld & (~bus.req_rsp | {N_CH{fifo_can_accept}});

  always_comb begin
    logic [CH_W-1:0] cand;
    cand      = '0;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int k = 0; k < N_CH; k++) begin
      cand = CH_W'((int'(rr_ptr_q) + k) % N_CH);
      if (!gnt_found && elig[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  assign fire = out_free && gnt_found;
  assign push = fire && bus.req_rsp[gnt_idx];

  always_comb begin
    bus.req_rdy = '0;
    if (fire) bus.req_rdy[gnt_idx] = 1'b1;
  end

  // ---------------- output register / pointer ----------------
  always_comb begin
    vld_d    = vld_q;
    dat_d    = dat_q;
    bp_d     = bp_q;
    rr_ptr_d = rr_ptr_q;
    if (out_free) vld_d = gnt_found;
    if (fire) begin
      dat_d    = bus.req_dat[gnt_idx];
      bp_d     = bus.req_bp[gnt_idx];
      rr_ptr_d = CH_W'(noc_next_ch(noc_ch_id_t'(gnt_idx), N_CH));
    end
  end

  assign err_d = err_q || (fifo_empty && bus.rin_vld);

  always_ff @(posedge fclk or posedge rst) begin
    if (rst) begin
      vld_q    <= 1'b0;
      dat_q    <= '0;
      bp_q     <= '0;
      rr_ptr_q <= '0;
      err_q    <= 1'b0;
    end else begin
      vld_q    <= vld_d;
      dat_q    <= dat_d;
      bp_q     <= bp_d;
      rr_ptr_q <= rr_ptr_d;
      err_q    <= err_d;
    end
  end

  assign bus.mem_vld    = vld_q;
  assign bus.mem_dat    = dat_q;
  assign bus.mem_bp     = bp_q;
  assign bus.err_orphan = err_q;

  noc_route_fifo #(
    .DEPTH (ROUTE_DEPTH),
    .WIDTH (CH_W)
  ) u_route_fifo (
    .clk_i   (fclk),
    .rst_i   (rst),
    .push_i  (push),
    .pop_i   (rsp_pop),
    .wdata_i (gnt_idx),
    .rdata_o (route_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

`ifdef NOC_ARB_PERF_CNT_EN
  logic [N_CH-1:0][31:0] grant_cnt_q;
  logic [31:0]           stall_cnt_q;

  always_ff @(posedge fclk or posedge rst) begin
    if (rst) begin
      grant_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (fire && gnt_idx == CH_W'(i) && grant_cnt_q[i] != '1)
          grant_cnt_q[i] <= grant_cnt_q[i] + 32'd1;
      end
      if (vld_q && !bus.mem_rdy && stall_cnt_q != '1)
        stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign grant_cnt = grant_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_noc_mem_arbiter.sv
// Self-checking bench for noc_mem_arbiter (N_CH=2, DAT_BYTES=32, ROUTE_DEPTH=4).
// A reference model (round-robin pointer, flit queue, route queue, orphan
// flag) predicts req_rdy, mem_* contents, rsp_* routing and err_orphan each
// cycle; scenario tasks add targeted checks on top.
module tb_noc_mem_arbiter;

  localparam int N_CH        = 2;
  localparam int DAT_BYTES   = 32;
  localparam int ROUTE_DEPTH = 4;
  localparam int DW          = DAT_BYTES * 8;
  localparam int FW          = DW + 6;

  logic fclk = 1'b0;
  logic rst  = 1'b1;

  int checks = 0;
  int errors = 0;

  logic [FW-1:0] exp_q[$];
  int            route_q[$];
  int            rr_m = 0;
  logic          exp_orphan = 1'b0;

  noc_mem_arbiter_if #(.N_CH(N_CH), .DAT_BYTES(DAT_BYTES)) bus ();

`ifdef NOC_ARB_PERF_CNT_EN
  logic [N_CH-1:0][31:0] grant_cnt;
  logic [31:0]           stall_cnt;
`endif

  noc_mem_arbiter #(
    .N_CH        (N_CH),
    .DAT_BYTES   (DAT_BYTES),
    .ROUTE_DEPTH (ROUTE_DEPTH)
  ) dut (
    .fclk (fclk),
    .rst  (rst),
    .bus  (bus)
`ifdef NOC_ARB_PERF_CNT_EN
    ,
    .grant_cnt (grant_cnt),
    .stall_cnt (stall_cnt)
`endif
  );

  // ---------------- clock / watchdog ----------------
  always #5 fclk = ~fclk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver helpers ----------------
  function automatic logic [DW-1:0] rand_dat();
    logic [DW-1:0] r;
    r = '0;
    for (int j = 0; j < DW / 32; j++) r[j*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic set_req(input int ch, input logic vld, input logic rsp);
    bus.req_vld[ch] = vld;
    bus.req_rsp[ch] = rsp;
    bus.req_dat[ch] = rand_dat();
    bus.req_bp[ch]  = 6'($urandom_range(0, 63));
  endtask

  task automatic clear_inputs();
    bus.req_vld = '0;
    bus.req_rsp = '0;
    bus.req_dat = '0;
    bus.req_bp  = '0;
    bus.mem_rdy = 1'b1;
    bus.rin_dat = '0;
    bus.rin_bp  = '0;
    bus.rin_vld = 1'b0;
    bus.rsp_rdy = '1;
  endtask

  task automatic clear_model();
    exp_q.delete();
    route_q.delete();
    rr_m       = 0;
    exp_orphan = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    clear_model();
    repeat (2) @(posedge fclk);
    #1;
    checks++;
    if (bus.mem_vld !== 1'b0 || bus.mem_dat !== '0 || bus.mem_bp !== '0) begin
      errors++;
      $display("FAIL reset_mem: vld=%b bp=%h dat=%h, required all zero", bus.mem_vld, bus.mem_bp, bus.mem_dat);
    end
    checks++;
    if (bus.err_orphan !== 1'b0 || bus.rsp_vld !== '0 || bus.rin_rdy !== 1'b1) begin
      errors++;
      $display("FAIL reset_rsp: err=%b rsp_vld=%b rin_rdy=%b, required 0/00/1", bus.err_orphan, bus.rsp_vld, bus.rin_rdy);
    end
    rst = 1'b0;
    #1;
  endtask

  // ---------------- scoreboard cycle ----------------
  // Called with inputs settled just before a rising edge; predicts and checks
  // this cycle's combinational outputs, commits model state, then advances.
  task automatic sb_cycle();
    logic [N_CH-1:0] exp_rdy, exp_rsp_vld;
    logic            exp_rin_rdy, pop_m, can_m, free_m;
    logic [FW-1:0]   got, exp;
    int              g, idx;

    exp_rsp_vld = '0;
    exp_rin_rdy = 1'b1;
    if (route_q.size() != 0) begin
      exp_rsp_vld[route_q[0]] = bus.rin_vld;
      exp_rin_rdy             = bus.rsp_rdy[route_q[0]];
    end
    pop_m = bus.rin_vld && (route_q.size() != 0) && exp_rin_rdy;

    checks++;
    if (bus.rsp_vld !== exp_rsp_vld || bus.rin_rdy !== exp_rin_rdy) begin
      errors++;
      $display("FAIL sb_route: rsp_vld=%b rin_rdy=%b, required %b/%b", bus.rsp_vld, bus.rin_rdy, exp_rsp_vld, exp_rin_rdy);
    end
    if (bus.rin_vld && route_q.size() != 0) begin
      checks++;
      if ({bus.rsp_dat, bus.rsp_bp} !== {bus.rin_dat, bus.rin_bp}) begin
        errors++;
        $display("FAIL sb_rsp_data: got bp %h, required bp %h", bus.rsp_bp, bus.rin_bp);
      end
    end

    free_m = (exp_q.size() == 0) || bus.mem_rdy;
    can_m  = (route_q.size() < ROUTE_DEPTH) || pop_m;
    g = -1;
    if (free_m) begin
      for (int k = 0; k < N_CH; k++) begin
        idx = (rr_m + k) % N_CH;
        if (g < 0 && bus.req_vld[idx] && (!bus.req_rsp[idx] || can_m)) g = idx;
      end
    end
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    checks++;
    if (bus.req_rdy !== exp_rdy) begin
      errors++;
      $display("FAIL sb_grant: req_rdy=%b, required %b", bus.req_rdy, exp_rdy);
    end

    if (exp_q.size() != 0 && bus.mem_rdy) begin
      got = {bus.mem_dat, bus.mem_bp};
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL sb_flit: got bp %h dat %h, required bp %h dat %h", got[5:0], got[FW-1:6], exp[5:0], exp[FW-1:6]);
      end
    end

    if (pop_m) void'(route_q.pop_front());
    else if (bus.rin_vld && route_q.size() == 0) exp_orphan = 1'b1;

    if (g >= 0) begin
      exp_q.push_back({bus.req_dat[g], bus.req_bp[g]});
      if (bus.req_rsp[g]) route_q.push_back(g);
      rr_m = (g + 1) % N_CH;
    end

    @(posedge fclk);
    #1;
    checks++;
    if (bus.mem_vld !== (exp_q.size() != 0) || bus.err_orphan !== exp_orphan) begin
      errors++;
      $display("FAIL sb_state: mem_vld=%b err=%b, required %b/%b", bus.mem_vld, bus.err_orphan, exp_q.size() != 0, exp_orphan);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    set_req(1, 1'b1, 1'b1);
    bus.mem_rdy = 1'b0;
    #1;
    sb_cycle();
    bus.req_vld = '0;
    bus.rin_vld = 1'b1;
    bus.rin_dat = rand_dat();
    bus.rsp_rdy = '0;
    #1;
    checks++;
    if (bus.rsp_vld !== 2'b10 || bus.mem_vld !== 1'b1) begin
      errors++;
      $display("FAIL reset_pre: rsp_vld=%b mem_vld=%b, required 10/1", bus.rsp_vld, bus.mem_vld);
    end
    #2;
    rst = 1'b1;   // mid-cycle: asynchronous clear
    #1;
    checks++;
    if (bus.mem_vld !== 1'b0 || bus.rsp_vld !== '0 || bus.err_orphan !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: mem_vld=%b rsp_vld=%b err=%b, required 0/00/0", bus.mem_vld, bus.rsp_vld, bus.err_orphan);
    end
    clear_model();
    @(posedge fclk);
    #1;
    rst = 1'b0;
    #1;
    sb_cycle();   // response after reset has no route: orphan
    checks++;
    if (bus.err_orphan !== 1'b1) begin
      errors++;
      $display("FAIL reset_orphan: err=%b, required 1", bus.err_orphan);
    end
    bus.rin_vld = 1'b0;
    bus.rsp_rdy = '1;
  endtask

  task automatic test_fairness();
    logic [N_CH-1:0] exp_r;
    logic [FW-1:0]   sent;
    do_reset();
    set_req(0, 1'b1, 1'b0);
    set_req(1, 1'b1, 1'b0);
    for (int c = 0; c < 6; c++) begin
      #1;
      exp_r = '0;
      exp_r[c % 2] = 1'b1;
      checks++;
      if (bus.req_rdy !== exp_r) begin
        errors++;
        $display("FAIL fair_grant%0d: req_rdy=%b, required %b", c, bus.req_rdy, exp_r);
      end
      sent = {bus.req_dat[c % 2], bus.req_bp[c % 2]};
      sb_cycle();
      checks++;
      if (bus.mem_vld !== 1'b1 || {bus.mem_dat, bus.mem_bp} !== sent) begin
        errors++;
        $display("FAIL fair_latency%0d: mem_vld=%b bp=%h, required 1/%h", c, bus.mem_vld, bus.mem_bp, sent[5:0]);
      end
      set_req(c % 2, 1'b1, 1'b0);
    end
    bus.req_vld = '0;
    #1;
    sb_cycle();
  endtask

  task automatic test_backpressure();
    logic [FW-1:0] flit_a, flit_b;
    do_reset();
    set_req(0, 1'b1, 1'b0);
    flit_a = {bus.req_dat[0], bus.req_bp[0]};
    #1;
    sb_cycle();
    bus.mem_rdy = 1'b0;
    set_req(0, 1'b1, 1'b0);
    flit_b = {bus.req_dat[0], bus.req_bp[0]};
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++;
      if (bus.req_rdy !== '0 || {bus.mem_dat, bus.mem_bp} !== flit_a || bus.mem_vld !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold%0d: req_rdy=%b mem_bp=%h, required 00/%h", c, bus.req_rdy, bus.mem_bp, flit_a[5:0]);
      end
      sb_cycle();
    end
    bus.mem_rdy = 1'b1;
    #1;
    checks++;
    if (bus.req_rdy !== 2'b01) begin
      errors++;
      $display("FAIL bp_release: req_rdy=%b, required 01", bus.req_rdy);
    end
    sb_cycle();
    checks++;
    if ({bus.mem_dat, bus.mem_bp} !== flit_b) begin
      errors++;
      $display("FAIL bp_next: mem_bp=%h, required %h", bus.mem_bp, flit_b[5:0]);
    end
    bus.req_vld = '0;
    #1;
    sb_cycle();
  endtask

  task automatic test_route_full();
    do_reset();
    for (int c = 0; c < ROUTE_DEPTH; c++) begin
      set_req(1, 1'b1, 1'b1);
      #1;
      sb_cycle();
    end
    set_req(1, 1'b1, 1'b1);
    set_req(0, 1'b1, 1'b0);
    #1;
    checks++;
    if (bus.req_rdy !== 2'b01) begin
      errors++;
      $display("FAIL full_posted: req_rdy=%b, required 01", bus.req_rdy);
    end
    sb_cycle();
    bus.req_vld[0] = 1'b0;
    #1;
    checks++;
    if (bus.req_rdy !== 2'b00) begin
      errors++;
      $display("FAIL full_blocked: req_rdy=%b, required 00", bus.req_rdy);
    end
    sb_cycle();
    bus.rin_vld = 1'b1;
    bus.rin_dat = rand_dat();
    bus.rin_bp  = 6'($urandom_range(0, 63));
    #1;
    checks++;
    if (bus.req_rdy !== 2'b10 || bus.rsp_vld !== 2'b10) begin
      errors++;
      $display("FAIL full_pop_grant: req_rdy=%b rsp_vld=%b, required 10/10", bus.req_rdy, bus.rsp_vld);
    end
    sb_cycle();
    bus.rin_vld = 1'b0;
    bus.req_vld = '0;
    #1;
    sb_cycle();
  endtask

  task automatic test_routing();
    do_reset();
    set_req(0, 1'b1, 1'b1); #1; sb_cycle();
    bus.req_vld[0] = 1'b0;
    set_req(1, 1'b1, 1'b1); #1; sb_cycle();
    bus.req_vld[1] = 1'b0;
    set_req(0, 1'b1, 1'b1); #1; sb_cycle();
    bus.req_vld = '0;
    #1;
    sb_cycle();
    bus.rin_vld = 1'b1;
    bus.rin_dat = rand_dat();
    bus.rin_bp  = 6'd1;
    #1;
    checks++;
    if (bus.rsp_vld !== 2'b01) begin
      errors++;
      $display("FAIL route_r1: rsp_vld=%b, required 01", bus.rsp_vld);
    end
    sb_cycle();
    bus.rin_dat = rand_dat();
    bus.rin_bp  = 6'd2;
    bus.rsp_rdy = 2'b01;
    #1;
    checks++;
    if (bus.rsp_vld !== 2'b10 || bus.rin_rdy !== 1'b0) begin
      errors++;
      $display("FAIL route_r2_stall: rsp_vld=%b rin_rdy=%b, required 10/0", bus.rsp_vld, bus.rin_rdy);
    end
    sb_cycle();
    bus.rsp_rdy = 2'b11;
    #1;
    sb_cycle();
    bus.rin_dat = rand_dat();
    bus.rin_bp  = 6'd3;
    #1;
    checks++;
    if (bus.rsp_vld !== 2'b01) begin
      errors++;
      $display("FAIL route_r3: rsp_vld=%b, required 01", bus.rsp_vld);
    end
    sb_cycle();
    bus.rin_vld = 1'b0;
    #1;
    sb_cycle();
    checks++;
    if (route_q.size() != 0 || bus.err_orphan !== 1'b0) begin
      errors++;
      $display("FAIL route_done: routes left %0d err=%b, required 0/0", route_q.size(), bus.err_orphan);
    end
  endtask

  task automatic test_orphan();
    do_reset();
    bus.rin_vld = 1'b1;
    bus.rin_dat = rand_dat();
    #1;
    checks++;
    if (bus.rin_rdy !== 1'b1 || bus.rsp_vld !== '0) begin
      errors++;
      $display("FAIL orphan_accept: rin_rdy=%b rsp_vld=%b, required 1/00", bus.rin_rdy, bus.rsp_vld);
    end
    sb_cycle();
    bus.rin_vld = 1'b0;
    #1;
    repeat (3) sb_cycle();
    checks++;
    if (bus.err_orphan !== 1'b1) begin
      errors++;
      $display("FAIL orphan_sticky: err=%b, required 1", bus.err_orphan);
    end
    do_reset();
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < N_CH; i++) set_req(i, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      bus.mem_rdy = ($urandom_range(0, 3) != 0);
      bus.rin_vld = ($urandom_range(0, 2) == 0);
      bus.rin_dat = rand_dat();
      bus.rin_bp  = 6'($urandom_range(0, 63));
      bus.rsp_rdy = N_CH'($urandom_range(0, (1 << N_CH) - 1));
      #1;
      sb_cycle();
    end
    clear_inputs();
    #1;
    sb_cycle();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_fairness();
    test_backpressure();
    test_route_full();
    test_routing();
    test_orphan();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
